// File: rtl/seg7_ctrl_n.sv
// Avalon-MM seven-segment controller for NUM_DIGITS static digits: hex/raw decode, blink, PWM dimming, polarity.
// Optional decimal-point outputs (coe_dp) are built when SEG7_DP_EN is defined.
module seg7_ctrl_n #(
    parameter int NUM_DIGITS = 2,
    parameter int ADDR_W     = 4,
    parameter int BLINK_DIV  = 25000000,
    parameter int PWM_BITS   = 4
) (
    input  logic                      csi_clk,
    input  logic                      csi_reset,
    input  logic [ADDR_W-1:0]         avs_s1_address,
    input  logic                      avs_s1_read,
    input  logic                      avs_s1_write,
    input  logic [15:0]               avs_s1_writedata,
    input  logic [1:0]                avs_s1_byteenable,
    output logic [15:0]               avs_s1_readdata,
`ifdef SEG7_DP_EN
    output logic [NUM_DIGITS-1:0]     coe_dp,
`endif
    output logic [NUM_DIGITS*7-1:0]   coe_seg
);

`ifdef SEG7_DP_EN
    localparam int DIG_W = 8;
`else
    localparam int DIG_W = 7;
`endif
    localparam int PRE_W = $clog2(BLINK_DIV);

    logic                  ctrl_en;
    logic                  ctrl_inv;
    logic [NUM_DIGITS-1:0] decode_r;
    logic [NUM_DIGITS-1:0] blink_r;
    logic [PWM_BITS-1:0]   duty_r;
    logic [DIG_W-1:0]      digit_r [NUM_DIGITS];

    logic [PRE_W-1:0]      pre_cnt;
    logic                  blink_phase;
    logic [PWM_BITS-1:0]   pwm_cnt;

    logic [15:0]           rd_mux;
    logic                  pwm_on;
    logic [NUM_DIGITS-1:0] lit;
    logic [NUM_DIGITS*7-1:0] seg_p0;

    // Every register is at most 8 bits wide, so the upper byte lane never lands anywhere.
    logic unused_hi;
    assign unused_hi = ^{avs_s1_writedata[15:7], avs_s1_byteenable[1]};

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            ctrl_en  <= 1'b1;
            ctrl_inv <= 1'b1;
            decode_r <= '1;
            blink_r  <= '0;
            duty_r   <= '1;
            for (int k = 0; k < NUM_DIGITS; k++) digit_r[k] <= '0;
        end else if (avs_s1_write && avs_s1_byteenable[0]) begin
            if (avs_s1_address == ADDR_W'(0)) begin
                ctrl_en  <= avs_s1_writedata[0];
                ctrl_inv <= avs_s1_writedata[1];
            end
            if (avs_s1_address == ADDR_W'(1)) decode_r <= avs_s1_writedata[NUM_DIGITS-1:0];
            if (avs_s1_address == ADDR_W'(2)) blink_r  <= avs_s1_writedata[NUM_DIGITS-1:0];
            if (avs_s1_address == ADDR_W'(3)) duty_r   <= avs_s1_writedata[PWM_BITS-1:0];
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (avs_s1_address == ADDR_W'(4 + k)) digit_r[k] <= avs_s1_writedata[DIG_W-1:0];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (avs_s1_address == ADDR_W'(0)) rd_mux[1:0] = {ctrl_inv, ctrl_en};
        if (avs_s1_address == ADDR_W'(1)) rd_mux[NUM_DIGITS-1:0] = decode_r;
        if (avs_s1_address == ADDR_W'(2)) rd_mux[NUM_DIGITS-1:0] = blink_r;
        if (avs_s1_address == ADDR_W'(3)) rd_mux[PWM_BITS-1:0] = duty_r;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (avs_s1_address == ADDR_W'(4 + k)) rd_mux[DIG_W-1:0] = digit_r[k];
        end
    end

    always_ff @(posedge csi_clk) begin
        if (csi_reset) avs_s1_readdata <= '0;
        else if (avs_s1_read) avs_s1_readdata <= rd_mux;
    end

    // Blink prescaler and PWM counter free-run; register writes never disturb them.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            pre_cnt     <= '0;
            blink_phase <= 1'b0;
            pwm_cnt     <= '0;
        end else begin
            if (pre_cnt == PRE_W'(BLINK_DIV - 1)) begin
                pre_cnt     <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // p0: combinational segment pattern from current register/counter state
    always_comb begin
        pwm_on = (pwm_cnt <= duty_r);
        lit    = '0;
        seg_p0 = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            lit[k] = ctrl_en & pwm_on & ~(blink_r[k] & blink_phase);
            seg_p0[7*k +: 7] = lit[k] ? (decode_r[k] ? hex7(digit_r[k][3:0]) : digit_r[k][6:0]) : 7'h00;
            if (ctrl_inv) seg_p0[7*k +: 7] = ~seg_p0[7*k +: 7];
        end
    end

    // p1: registered pin drivers
    always_ff @(posedge csi_clk) begin
        if (csi_reset) coe_seg <= '1;
        else coe_seg <= seg_p0;
    end

`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0] dp_p0;

    always_comb begin
        dp_p0 = '0;
        for (int k = 0; k < NUM_DIGITS; k++) dp_p0[k] = (lit[k] & digit_r[k][7]) ^ ctrl_inv;
    end

    always_ff @(posedge csi_clk) begin
        if (csi_reset) coe_dp <= '1;
        else coe_dp <= dp_p0;
    end
`endif

endmodule

// File: tb/tb_seg7_ctrl_n.sv
// Directed bench for seg7_ctrl_n with NUM_DIGITS=2, BLINK_DIV=4, PWM_BITS=4.
module tb_seg7_ctrl_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] rdata;
    logic [13:0] seg;
`ifdef SEG7_DP_EN
    logic [1:0]  dp;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg7_ctrl_n #(
        .NUM_DIGITS(2),
        .ADDR_W(4),
        .BLINK_DIV(4),
        .PWM_BITS(4)
    ) dut (
        .csi_clk(clk),
        .csi_reset(rst),
        .avs_s1_address(addr),
        .avs_s1_read(rd),
        .avs_s1_write(wr),
        .avs_s1_writedata(wdata),
        .avs_s1_byteenable(be),
        .avs_s1_readdata(rdata),
`ifdef SEG7_DP_EN
        .coe_dp(dp),
`endif
        .coe_seg(seg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end on a negedge and occupy exactly one posedge.
    task automatic wr_reg(input int a, input logic [15:0] d, input logic [1:0] b);
        addr = 4'(a); wdata = d; be = b; wr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic rd_reg(input int a, output logic [15:0] q);
        addr = 4'(a); rd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd = 1'b0;
        q = rdata;
    endtask

    task automatic rw_reg(input int a, input logic [15:0] d, output logic [15:0] q);
        addr = 4'(a); wdata = d; be = 2'b11; wr = 1'b1; rd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        q = rdata;
    endtask

    initial begin
        logic [15:0] q;
        logic [6:0]  exp0;
        int          phase;
        int          lit0;
        int          lit1;

        rst = 1'b1; addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0; be = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_seg", 32'(seg), 32'h3FFF);
        check("rst_rdata", 32'(rdata), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_seg", 32'(seg), 32'h2040);

        rd_reg(0, q); check("rd_ctrl", 32'(q), 32'h3);
        rd_reg(1, q); check("rd_decode", 32'(q), 32'h3);
        rd_reg(2, q); check("rd_blink", 32'(q), 32'h0);
        rd_reg(3, q); check("rd_duty", 32'(q), 32'hF);
        @(negedge clk);
        check("rd_hold", 32'(rdata), 32'hF);
        rd_reg(4, q); check("rd_dig0", 32'(q), 32'h0);

        // Hex decode, inverted pins; new digit appears one edge after the write
        wr_reg(4, 16'h0008, 2'b11);
        check("dig0_lat", 32'(seg), 32'h2040);
        @(negedge clk);
        check("dig0_hex8", 32'(seg), 32'h2000);
        wr_reg(5, 16'h000A, 2'b11);
        @(negedge clk);
        check("dig1_hexA", 32'(seg), 32'h0400);
        rd_reg(4, q); check("rd_dig0_8", 32'(q), 32'h8);
        rd_reg(5, q); check("rd_dig1_A", 32'(q), 32'hA);

        // Raw mode, then non-inverted pins
        wr_reg(1, 16'h0000, 2'b11);
        wr_reg(4, 16'h0055, 2'b11);
        @(negedge clk);
        check("raw_inv", 32'(seg[6:0]), 32'h2A);
        wr_reg(0, 16'h0001, 2'b11);
        @(negedge clk);
        check("raw_noinv", 32'(seg), 32'h0555);

        // Byte lanes, dropped bits, unmapped addresses, read-during-write
        wr_reg(4, 16'h0000, 2'b11);
        wr_reg(4, 16'hFFFF, 2'b10);
        rd_reg(4, q); check("be_hi_only", 32'(q), 32'h0);
        wr_reg(5, 16'h00FF, 2'b01);
        rd_reg(5, q);
`ifdef SEG7_DP_EN
        check("dig_width", 32'(q), 32'hFF);
`else
        check("dig_width", 32'(q), 32'h7F);
`endif
        wr_reg(2, 16'hFFFF, 2'b11);
        rd_reg(2, q); check("blink_width", 32'(q), 32'h3);
        wr_reg(2, 16'h0000, 2'b11);
        wr_reg(3, 16'hFFF7, 2'b11);
        rd_reg(3, q); check("duty_width", 32'(q), 32'h7);
        wr_reg(7, 16'hFFFF, 2'b11);
        rd_reg(7, q); check("rd_addr7", 32'(q), 32'h0);
        rd_reg(15, q); check("rd_addr15", 32'(q), 32'h0);
        rw_reg(5, 16'h0012, q); check("rw_old", 32'(q), 32'h7F);
        rd_reg(5, q); check("rw_new", 32'(q), 32'h12);

        // Mid-operation reset with a concurrent DUTY write that must be discarded
        addr = 4'd3; wdata = 16'h0000; be = 2'b11; wr = 1'b1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0; rst = 1'b0;
        check("mid_rst_seg", 32'(seg), 32'h3FFF);
        check("mid_rst_rdata", 32'(rdata), 32'h0);

        // Prescaler restarted at 0: phase toggles after edges 4, 8, 12, 16
        wr_reg(1, 16'h0000, 2'b11);
        wr_reg(4, 16'h007F, 2'b11);
        wr_reg(5, 16'h0012, 2'b11);
        wr_reg(2, 16'h0001, 2'b11);
        wr_reg(0, 16'h0001, 2'b11);
        for (int k = 6; k <= 20; k++) begin
            @(negedge clk);
            phase = ((k - 1) / 4) % 2;
            exp0 = (phase == 1) ? 7'h00 : 7'h7F;
            check($sformatf("blink0_%0d", k), 32'(seg[6:0]), 32'(exp0));
            check($sformatf("blink1_%0d", k), 32'(seg[13:7]), 32'h12);
        end
        rd_reg(3, q); check("rst_discard", 32'(q), 32'hF);

        // PWM duty over two full 16-clock periods
        wr_reg(2, 16'h0000, 2'b11);
        wr_reg(3, 16'h0003, 2'b11);
        @(negedge clk);
        lit0 = 0; lit1 = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (seg[6:0] == 7'h7F) lit0++;
            if (seg[13:7] == 7'h12) lit1++;
        end
        check("pwm3_d0", 32'(lit0), 32'd8);
        check("pwm3_d1", 32'(lit1), 32'd8);

        wr_reg(3, 16'h0000, 2'b11);
        @(negedge clk);
        lit0 = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (seg[6:0] == 7'h7F) lit0++;
        end
        check("pwm0_d0", 32'(lit0), 32'd2);

        wr_reg(3, 16'h000F, 2'b11);
        @(negedge clk);
        lit0 = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (seg[6:0] == 7'h7F) lit0++;
        end
        check("pwm15_d0", 32'(lit0), 32'd32);

        // Global disable blanks everything (pins active-high here)
        wr_reg(0, 16'h0000, 2'b11);
        @(negedge clk);
        check("en_off", 32'(seg), 32'h0000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
